// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : shared flag bit indices and branch condition codes
// Revision : 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] flags);
    logic n, z, v, c;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    c = flags[FLAG_C];
    case (code)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = ~c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = c & ~z;
      COND_LS: cond_eval = ~c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo_2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_fifo_2 : two-entry FIFO with occupancy count and flush
// Revision : 1.0
// ---------------------------------------------------------------------------
module result_fifo_2 #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Write slot sits one past the head when a single entry is held.
  assign wr_ptr  = rd_ptr_q ^ count_q[0];
  assign push_ok = push & (count_q != 2'd2);
  assign pop_ok  = pop & (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr] = wdata;
      end
      if (pop_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_result_stage : ALU result buffer, NZVC status register, branch condition
// Revision : 1.0
// ---------------------------------------------------------------------------
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int size   = 16,
  parameter int addr_w = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [size-1:0]   in_result,
  input  logic [addr_w-1:0] in_dest,
  input  logic [3:0]        in_flags_n_z_v_c,
  input  logic [3:0]        in_flag_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [size-1:0]   out_result,
  output logic [addr_w-1:0] out_dest,
  input  logic              flush,
  input  logic              flags_wr_en,
  input  logic [3:0]        flags_wr_data,
  output logic [3:0]        flags_n_z_v_c,
  input  logic [3:0]        cond,
  output logic              cond_true
);

  localparam int ENTRY_W = size + addr_w;

  logic [1:0]         count;
  logic [ENTRY_W-1:0] head;
  logic               accept;
  logic               pop;
  logic [3:0]         flags_q, flags_d;

  // in_ready derives from the registered count only, never from out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  result_fifo_2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .flush (flush),
    .wdata ({in_result, in_dest}),
    .rdata (head),
    .count (count)
  );

  assign out_result = head[ENTRY_W-1:addr_w];
  assign out_dest   = head[addr_w-1:0];

  // Flags are architectural at accept time, so a flush does not suppress them.
  always_comb begin
    flags_d = flags_q;
    if (flags_wr_en) begin
      flags_d = flags_wr_data;
    end else if (accept) begin
      flags_d = (flags_q & ~in_flag_mask) | (in_flags_n_z_v_c & in_flag_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_n_z_v_c = flags_q;
  assign cond_true     = cond_eval(cond, flags_q);

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_result_stage : directed stimulus with a queue-based scoreboard monitor
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [2:0]  in_dest;
  logic [3:0]  in_flags_n_z_v_c;
  logic [3:0]  in_flag_mask;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_dest;
  logic        flush;
  logic        flags_wr_en;
  logic [3:0]  flags_wr_data;
  logic [3:0]  flags_n_z_v_c;
  logic [3:0]  cond;
  logic        cond_true;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] r;
    logic [2:0]  d;
  } ent_t;

  ent_t       sb_q[$];
  logic [3:0] m_flags = 4'b0000;
  int         m_cnt;
  logic       m_acc;
  logic       m_pop;

  always #5 clk = ~clk;

  alu_result_stage #(
    .size   (16),
    .addr_w (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_result        (in_result),
    .in_dest          (in_dest),
    .in_flags_n_z_v_c (in_flags_n_z_v_c),
    .in_flag_mask     (in_flag_mask),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_dest         (out_dest),
    .flush            (flush),
    .flags_wr_en      (flags_wr_en),
    .flags_wr_data    (flags_wr_data),
    .flags_n_z_v_c    (flags_n_z_v_c),
    .cond             (cond),
    .cond_true        (cond_true)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !cy || z;
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return z || (n != v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: compare DUT against the reference state, then advance it from the
  // inputs that will be applied at the coming rising edge.
  always @(negedge clk) begin
    m_cnt = sb_q.size();
    chk("mon_in_ready", in_ready, m_cnt != 2);
    chk("mon_out_valid", out_valid, m_cnt != 0);
    if (m_cnt != 0) begin
      chk("mon_out_result", out_result, sb_q[0].r);
      chk("mon_out_dest", out_dest, sb_q[0].d);
    end
    chk("mon_flags", flags_n_z_v_c, m_flags);
    chk("mon_cond_true", cond_true, exp_cond(cond, m_flags));
    if (rst) begin
      sb_q.delete();
      m_flags = 4'b0000;
    end else begin
      m_acc = in_valid && (m_cnt != 2);
      m_pop = out_ready && (m_cnt != 0);
      if (flags_wr_en) m_flags = flags_wr_data;
      else if (m_acc) m_flags = (m_flags & ~in_flag_mask) | (in_flags_n_z_v_c & in_flag_mask);
      if (flush) begin
        sb_q.delete();
      end else begin
        if (m_pop) sb_q.delete(0);
        if (m_acc) sb_q.push_back({in_result, in_dest});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] r, input logic [2:0] d, input logic [3:0] f, input logic [3:0] m);
    in_valid         = 1'b1;
    in_result        = r;
    in_dest          = d;
    in_flags_n_z_v_c = f;
    in_flag_mask     = m;
  endtask

  task automatic idle();
    in_valid         = 1'b0;
    in_result        = 16'h0;
    in_dest          = 3'd0;
    in_flags_n_z_v_c = 4'h0;
    in_flag_mask     = 4'h0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_dest"}, out_dest, 0);
    chk({tag, "_flags"}, flags_n_z_v_c, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; out_ready = 1'b0; flush = 1'b0;
    flags_wr_en = 1'b0; flags_wr_data = 4'h0; cond = 4'd0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    tick();
    rst = 1'b0;

    // Single result, one cycle to out_valid
    drive(16'h1234, 3'd3, 4'b0000, 4'b1111);
    tick(); idle();
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_result", out_result, 16'h1234);
    chk("t1_out_dest", out_dest, 3);
    chk("t1_flags", flags_n_z_v_c, 4'b0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Back-pressure: two accepted, third stalls until the first pop
    drive(16'hA001, 3'd1, 4'h0, 4'h0); tick();
    drive(16'hB002, 3'd2, 4'h0, 4'h0); tick();
    drive(16'hC003, 3'd5, 4'h0, 4'h0);
    @(negedge clk);
    chk("t2_full_in_ready", in_ready, 0);
    chk("t2_head", out_result, 16'hA001);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_after_pop_in_ready", in_ready, 1);
    chk("t2_second_head", out_result, 16'hB002);
    tick(); idle();
    @(negedge clk);
    chk("t2_third_result", out_result, 16'hC003);
    chk("t2_third_dest", out_dest, 5);
    tick();
    @(negedge clk);
    chk("t2_drained", out_valid, 0);

    // Sustained throughput with out_ready held high
    for (int i = 0; i < 4; i++) begin
      drive(16'h0100 + 16'(i), 3'(i), 4'h0, 4'h0);
      tick();
    end
    idle();
    tick();

    // Masked flag update and signed compare conditions
    drive(16'h3333, 3'd4, 4'b1010, 4'b1111); tick();
    drive(16'h4444, 3'd6, 4'b0101, 4'b0011);
    cond = 4'd10;
    tick(); idle();
    @(negedge clk);
    chk("t3_flags", flags_n_z_v_c, 4'b1001);
    chk("t3_ge", cond_true, 0);
    tick();
    cond = 4'd11;
    @(negedge clk);
    chk("t3_lt", cond_true, 1);

    // Direct write wins over a simultaneous accept
    tick();
    drive(16'h5555, 3'd7, 4'b1111, 4'b1111);
    flags_wr_en = 1'b1; flags_wr_data = 4'b0100; cond = 4'd0;
    tick(); idle();
    flags_wr_en = 1'b0;
    @(negedge clk);
    chk("t4_flags", flags_n_z_v_c, 4'b0100);
    chk("t4_eq", cond_true, 1);

    // Flush at full occupancy, then flush with a concurrent accept
    tick();
    out_ready = 1'b0;
    drive(16'h6666, 3'd1, 4'h0, 4'h0); tick();
    drive(16'h7777, 3'd2, 4'h0, 4'h0); tick(); idle();
    @(negedge clk);
    chk("t5_full", in_ready, 0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_flush_out_valid", out_valid, 0);
    chk("t5_flush_in_ready", in_ready, 1);
    tick();
    drive(16'h8888, 3'd3, 4'h0, 4'h0); tick();
    drive(16'h9999, 3'd4, 4'b0001, 4'b0001);
    flush = 1'b1;
    tick(); idle();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_acc_flush_out_valid", out_valid, 0);
    chk("t5_acc_flush_in_ready", in_ready, 1);
    chk("t5_acc_flush_flags", flags_n_z_v_c, 4'b0101);

    // Reset mid-stream
    tick();
    drive(16'hABCD, 3'd5, 4'h0, 4'h0); tick(); idle();
    @(negedge clk);
    chk("t6_pre_reset_valid", out_valid, 1);
    tick();
    rst = 1'b1; cond = 4'd14;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("t6");
    chk("t6_al", cond_true, 1);
    tick();
    cond = 4'd15;
    @(negedge clk);
    chk("t6_nv", cond_true, 0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
